// File: rtl/gap_pkg.sv
// gap_pkg: gap state encoding and a saturating-increment helper shared by the gap detector.
package gap_pkg;

    typedef enum logic [1:0] {
        GAP_WORK  = 2'd0,
        GAP_SHORT = 2'd1,
        GAP_IDLE  = 2'd2
    } gap_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/gap_classifier.sv
// gap_classifier: combinational raw SHORT/WORK/IDLE decision with hysteresis, relative to the current state.
module gap_classifier
    import gap_pkg::*;
#(
    parameter int DATA_WIDTH = 17
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] short_th,
    input  logic [DATA_WIDTH-1:0] idle_th,
    input  logic [DATA_WIDTH-1:0] hyst,
    input  gap_state_t            state,
    output gap_state_t            raw
);

    logic [DATA_WIDTH:0]   short_sum;
    logic [DATA_WIDTH:0]   idle_diff;
    logic [DATA_WIDTH-1:0] short_hi;
    logic [DATA_WIDTH-1:0] idle_lo;
    logic                  below_short;
    logic                  above_idle;
    logic                  overlap;

    // One extra bit catches overflow/underflow so the exit bands saturate instead of wrapping
    assign short_sum   = {1'b0, short_th} + {1'b0, hyst};
    assign idle_diff   = {1'b0, idle_th} - {1'b0, hyst};
    assign short_hi    = short_sum[DATA_WIDTH] ? '1 : short_sum[DATA_WIDTH-1:0];
    assign idle_lo     = idle_diff[DATA_WIDTH] ? '0 : idle_diff[DATA_WIDTH-1:0];
    assign below_short = data_in < short_th;
    assign above_idle  = data_in > idle_th;
    assign overlap     = short_th >= idle_th;

    // Overlapping thresholds let a short condition win from any state
    assign raw = (overlap && below_short) ? GAP_SHORT :
                 (state == GAP_SHORT)     ? ((data_in >= short_hi) ? (above_idle ? GAP_IDLE : GAP_WORK) : GAP_SHORT) :
                 (state == GAP_IDLE)      ? ((data_in <= idle_lo) ? (below_short ? GAP_SHORT : GAP_WORK) : GAP_IDLE) :
                 below_short              ? GAP_SHORT :
                 above_idle               ? GAP_IDLE  : GAP_WORK;

endmodule

// File: rtl/gap_state_detector.sv
// gap_state_detector: debounced gap state FSM over averaged gap voltage.
// Define GAP_STAT_EN to add saturating SHORT/IDLE entry counters.
module gap_state_detector
    import gap_pkg::*;
#(
    parameter int DATA_WIDTH = 17,
    parameter int DEB_WIDTH  = 8
`ifdef GAP_STAT_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  clock,
    input  logic                  aclr_n,
    input  logic                  sclr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] short_th,
    input  logic [DATA_WIDTH-1:0] idle_th,
    input  logic [DATA_WIDTH-1:0] hyst,
    input  logic [DEB_WIDTH-1:0]  deb,
    output gap_state_t            state,
    output logic                  state_chg,
    output logic                  valid_out
`ifdef GAP_STAT_EN
    ,
    output logic [CNT_WIDTH-1:0]  short_cnt,
    output logic [CNT_WIDTH-1:0]  idle_cnt
`endif
);

    gap_state_t           raw;
    gap_state_t           cand;
    gap_state_t           state_nxt;
    gap_state_t           cand_nxt;
    logic [DEB_WIDTH-1:0] cnt;
    logic [DEB_WIDTH-1:0] cnt_nxt;
    logic [DEB_WIDTH-1:0] run;
    logic [DEB_WIDTH-1:0] target;
    logic                 chg_nxt;
    logic                 vout_nxt;

    gap_classifier #(.DATA_WIDTH(DATA_WIDTH)) u_classifier (
        .data_in  (data_in),
        .short_th (short_th),
        .idle_th  (idle_th),
        .hyst     (hyst),
        .state    (state),
        .raw      (raw)
    );

    assign run    = (raw == cand) ? DEB_WIDTH'(sat_inc(32'(cnt), DEB_WIDTH)) : DEB_WIDTH'(1);
    assign target = (deb == '0) ? DEB_WIDTH'(1) : deb;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state     <= GAP_IDLE;
            cand      <= GAP_IDLE;
            cnt       <= '0;
            state_chg <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            state_chg <= chg_nxt;
            valid_out <= vout_nxt;
        end
    end

    // run >= target so a deb lowered mid-debounce still commits
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        chg_nxt   = 1'b0;
        vout_nxt  = valid_out;
        if (valid_in) begin
            vout_nxt = 1'b1;
            if (raw == state) begin
                cnt_nxt = '0;
            end else if (run >= target) begin
                state_nxt = raw;
                cand_nxt  = raw;
                cnt_nxt   = '0;
                chg_nxt   = 1'b1;
            end else begin
                cand_nxt = raw;
                cnt_nxt  = run;
            end
        end
        if (sclr) begin
            state_nxt = GAP_IDLE;
            cand_nxt  = GAP_IDLE;
            cnt_nxt   = '0;
            chg_nxt   = 1'b0;
            vout_nxt  = 1'b0;
        end
    end

`ifdef GAP_STAT_EN
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            short_cnt <= '0;
            idle_cnt  <= '0;
        end else if (sclr) begin
            short_cnt <= '0;
            idle_cnt  <= '0;
        end else if (chg_nxt) begin
            short_cnt <= (state_nxt == GAP_SHORT) ? CNT_WIDTH'(sat_inc(32'(short_cnt), CNT_WIDTH)) : short_cnt;
            idle_cnt  <= (state_nxt == GAP_IDLE) ? CNT_WIDTH'(sat_inc(32'(idle_cnt), CNT_WIDTH)) : idle_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_gap_state_detector.sv
// tb_gap_state_detector: directed and randomized checks of gap_state_detector against a behavioural model.
module tb_gap_state_detector;
    import gap_pkg::*;

    localparam int DW   = 17;
    localparam int DBW  = 8;
    localparam int CW   = 2;
    localparam int DMAX = (1 << DW) - 1;
    localparam int CMAX = (1 << CW) - 1;
    localparam int W = 0, S = 1, I = 2;

    logic           clock = 1'b0;
    logic           aclr_n = 1'b0;
    logic           sclr = 1'b0;
    logic [DW-1:0]  data_in = '0;
    logic           valid_in = 1'b0;
    logic [DW-1:0]  short_th = '0;
    logic [DW-1:0]  idle_th = '0;
    logic [DW-1:0]  hyst = '0;
    logic [DBW-1:0] deb = '0;
    gap_state_t     state;
    logic           state_chg;
    logic           valid_out;
`ifdef GAP_STAT_EN
    logic [CW-1:0]  short_cnt;
    logic [CW-1:0]  idle_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    gap_state_detector #(
        .DATA_WIDTH(DW),
        .DEB_WIDTH (DBW)
`ifdef GAP_STAT_EN
        ,
        .CNT_WIDTH (CW)
`endif
    ) dut (
        .clock     (clock),
        .aclr_n    (aclr_n),
        .sclr      (sclr),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .short_th  (short_th),
        .idle_th   (idle_th),
        .hyst      (hyst),
        .deb       (deb),
        .state     (state),
        .state_chg (state_chg),
        .valid_out (valid_out)
`ifdef GAP_STAT_EN
        ,
        .short_cnt (short_cnt),
        .idle_cnt  (idle_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Behavioural model: state, pending class, length of its unbroken run, stats
    int m_state, m_cand, m_run, m_vld, m_chg, m_sc, m_ic;

    function automatic int classify(int d, int sh, int id, int hy, int cur);
        int hi, lo;
        hi = (sh + hy > DMAX) ? DMAX : sh + hy;
        lo = (id - hy < 0) ? 0 : id - hy;
        if (sh >= id && d < sh) return S;
        if (cur == S) return (d >= hi) ? ((d > id) ? I : W) : S;
        if (cur == I) return (d <= lo) ? ((d < sh) ? S : W) : I;
        return (d < sh) ? S : (d > id) ? I : W;
    endfunction

    always @(posedge clock or negedge aclr_n) begin
        if (!aclr_n || (aclr_n && sclr)) begin
            m_state <= I; m_cand <= I; m_run <= 0; m_chg <= 0; m_vld <= 0; m_sc <= 0; m_ic <= 0;
        end else if (valid_in) begin
            int r, need, len;
            r    = classify(int'(data_in), int'(short_th), int'(idle_th), int'(hyst), m_state);
            need = (deb == 0) ? 1 : int'(deb);
            len  = (r == m_cand) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
            m_vld <= 1;
            m_chg <= 0;
            if (r == m_state) begin
                m_run <= 0;
            end else if (len >= need) begin
                m_state <= r; m_cand <= r; m_run <= 0; m_chg <= 1;
                if (r == S) m_sc <= (m_sc < CMAX) ? m_sc + 1 : CMAX;
                if (r == I) m_ic <= (m_ic < CMAX) ? m_ic + 1 : CMAX;
            end else begin
                m_cand <= r; m_run <= len;
            end
        end else begin
            m_chg <= 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("state", int'(state), m_state);
        chk("state_chg", int'(state_chg), m_chg);
        chk("valid_out", int'(valid_out), m_vld);
`ifdef GAP_STAT_EN
        chk("short_cnt", int'(short_cnt), m_sc);
        chk("idle_cnt", int'(idle_cnt), m_ic);
`endif
    end

    task automatic cfg(input int sh, input int id, input int hy, input int d);
        short_th = DW'(sh); idle_th = DW'(id); hyst = DW'(hy); deb = DBW'(d);
    endtask

    task automatic step(input int d, input bit v = 1'b1, input bit c = 1'b0);
        data_in = DW'(d); valid_in = v; sclr = c;
        @(posedge clock);
        @(negedge clock);
        valid_in = 1'b0; sclr = 1'b0;
    endtask

    task automatic pin(input string name, input int exp_state, input int exp_chg, input int exp_vld);
        chk({name, " state"}, int'(state), exp_state);
        chk({name, " chg"}, int'(state_chg), exp_chg);
        chk({name, " valid"}, int'(valid_out), exp_vld);
        chk({name, " model"}, m_state, exp_state);
    endtask

    task automatic aclr_pulse();
        #1 aclr_n = 1'b0;
        #2 aclr_n = 1'b1;
    endtask

    initial begin
        cfg(100, 900, 20, 3);
        repeat (2) @(negedge clock);
        aclr_n = 1'b1;
        pin("reset", I, 0, 0);
        step(500); step(500);
        pin("t1 two", I, 0, 1);
        step(500, 1'b0);
        pin("t1 hold", I, 0, 1);
        step(500);
        pin("t1 work", W, 1, 1);
        step(500);
        pin("t1 pulse end", W, 0, 1);
        step(50); step(50); step(600); step(50); step(50);
        pin("t2 pending", W, 0, 1);
        step(50);
        pin("t2 short", S, 1, 1);
        repeat (5) step(110);
        pin("t3 hyst", S, 0, 1);
        step(120); step(120);
        pin("t3 two", S, 0, 1);
        step(120);
        pin("t3 work", W, 1, 1);
        cfg(100, 900, 20, 0);
        step(950);
        pin("t4 idle", I, 1, 1);
        cfg(950, 900, 20, 0);
        step(920);
        pin("t4 overlap", S, 1, 1);
        cfg(100, 900, 20, 3);
        step(500); step(500); step(500, 1'b1, 1'b1);
        pin("t5 sclr", I, 0, 0);
        step(500); step(500);
        aclr_pulse();
        @(negedge clock);
        pin("t5 aclr", I, 0, 0);
        step(500);
        pin("t5 restart", I, 0, 1);
        step(500); step(500);
        pin("t5 work", W, 1, 1);
`ifdef GAP_STAT_EN
        cfg(100, 900, 20, 1);
        repeat (5) begin step(50); step(500); end
        chk("t6 short_cnt sat", int'(short_cnt), 3);
`endif
        cfg(100, 900, 20, 1);
        step(950);
        pin("t6 idle", I, 1, 1);
        cfg(100, DMAX, DMAX, 1);
        step(1);
        pin("t6 no wrap", I, 0, 1);
        step(0);
        pin("t6 exit at 0", S, 1, 1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0)
                cfg($urandom_range(0, 1200), $urandom_range(0, 1200),
                    ($urandom_range(0, 19) == 0) ? DMAX : $urandom_range(0, 100), $urandom_range(0, 4));
            if ($urandom_range(0, 299) == 0) aclr_pulse();
            step(($urandom_range(0, 39) == 0) ? DMAX : $urandom_range(0, 1300),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
